// File: rtl/i2c_xact_seq_pkg.sv
// Shared encodings for the I2C register-transaction sequencer: master command/status
// bit positions, completion error codes, sequencer states and transfer phases.
package i2c_xact_seq_pkg;

    // i2c_master command word
    localparam int unsigned C_SZ    = 5;
    localparam int unsigned CB_STRT = 0;
    localparam int unsigned CB_STOP = 1;
    localparam int unsigned CB_WRTE = 2;
    localparam int unsigned CB_READ = 3;
    localparam int unsigned CB_NACK = 4;

    localparam logic [C_SZ-1:0] C_STRT = C_SZ'(1 << CB_STRT);
    localparam logic [C_SZ-1:0] C_STOP = C_SZ'(1 << CB_STOP);
    localparam logic [C_SZ-1:0] C_WRTE = C_SZ'(1 << CB_WRTE);
    localparam logic [C_SZ-1:0] C_READ = C_SZ'(1 << CB_READ);
    localparam logic [C_SZ-1:0] C_NACK = C_SZ'(1 << CB_NACK);

    // i2c_master status word
    localparam int unsigned S_SZ   = 5;
    localparam int unsigned SB_BSY = 0;
    localparam int unsigned SB_ACK = 1;
    localparam int unsigned SB_ERR = 2;
    localparam int unsigned SB_ALO = 3;
    localparam int unsigned SB_BBL = 4;

    typedef enum logic [2:0] {
        E_NONE  = 3'd0,
        E_NAKA  = 3'd1,
        E_NAKD  = 3'd2,
        E_ALO   = 3'd3,
        E_BBL   = 3'd4,
        E_PROTO = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        S_RST     = 3'd0,
        S_IDLE    = 3'd1,
        S_ISSUE   = 3'd2,
        S_ACPT    = 3'd3,
        S_WAIT    = 3'd4,
        S_EVAL    = 3'd5,
        S_BACKOFF = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        PH_ADDR  = 3'd0,
        PH_REG   = 3'd1,
        PH_RADDR = 3'd2,
        PH_DATA  = 3'd3,
        PH_RDAT  = 3'd4,
        PH_STOP  = 3'd5
    } phase_e;

    // Request header latched at accept
    typedef struct packed {
        logic       rd;
        logic [6:0] dev;
        logic [7:0] rga;
    } req_hdr_t;

endpackage

// File: rtl/i2c_xact_seq.sv
// Register-transaction sequencer driving i2c_master's cmd/dat/ws byte interface.
// Optional build macro: I2C_SEQ_RETRY_EN (ALO/BBL retry with backoff).
module i2c_xact_seq
    import i2c_xact_seq_pkg::*;
#(
`ifdef I2C_SEQ_RETRY_EN
    parameter int unsigned RETRIES = 3,
    parameter int unsigned BACKOFF = 255,
`endif
    parameter int unsigned LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rd,
    input  logic [6:0]       req_dev,
    input  logic [7:0]       req_reg,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic [2:0]       err_code,
    output logic [C_SZ-1:0]  m_cmd,
    output logic [7:0]       m_dat,
    output logic             m_ws,
    input  logic [S_SZ-1:0]  m_stat,
    input  logic [7:0]       m_dat_in
);

`ifdef I2C_SEQ_RETRY_EN
    localparam int unsigned ATT_W = $clog2(RETRIES + 1);
    localparam int unsigned BO_W  = $clog2(BACKOFF + 1);

    logic [ATT_W-1:0] attempts_q;
    logic [BO_W-1:0]  bo_q;
    logic [LEN_W-1:0] len_q;
    logic             wr_started_q;
    logic             retry_ok;
`endif

    state_e           state_q;
    phase_e           phase_q;
    req_hdr_t         hdr_q;
    logic [LEN_W-1:0] cnt_q;
    err_e             err_q;
    err_e             err_pend_q;
    logic             req_ready_q, wr_ready_q, rd_valid_q, done_q, m_ws_q;
    logic [C_SZ-1:0]  m_cmd_q;
    logic [7:0]       m_dat_q, rd_data_q;

    logic             last;
    logic             issue_ok;
    logic [C_SZ-1:0]  cmd_d;
    logic [7:0]       dat_d;
    err_e             err_d;

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err_code  = err_q;
    assign m_cmd     = m_cmd_q;
    assign m_dat     = m_dat_q;
    assign m_ws      = m_ws_q;

    assign last = (cnt_q == '0);

    // Command/data byte for the current phase and whether it can be issued now
    always_comb begin
        cmd_d    = '0;
        dat_d    = '0;
        issue_ok = !m_stat[SB_BSY];
        unique case (phase_q)
            PH_ADDR: begin
                cmd_d = C_STRT | C_WRTE;
                dat_d = {hdr_q.dev, 1'b0};
            end
            PH_REG: begin
                cmd_d = C_WRTE;
                dat_d = hdr_q.rga;
            end
            PH_RADDR: begin
                cmd_d = C_STRT | C_WRTE;
                dat_d = {hdr_q.dev, 1'b1};
            end
            PH_DATA: begin
                cmd_d    = C_WRTE | (last ? C_STOP : C_SZ'(0));
                dat_d    = wr_data;
                issue_ok = !m_stat[SB_BSY] && wr_valid;
            end
            PH_RDAT: cmd_d = C_READ | (last ? (C_NACK | C_STOP) : C_SZ'(0));
            PH_STOP: cmd_d = C_STOP;
            default: ;
        endcase
    end

    // Classify a master-reported error
    always_comb begin
        err_d = E_PROTO;
        if (m_stat[SB_ALO])      err_d = E_ALO;
        else if (m_stat[SB_BBL]) err_d = E_BBL;
    end

`ifdef I2C_SEQ_RETRY_EN
    // Retry only while the write stream is untouched, since consumed bytes cannot be replayed
    assign retry_ok = (m_stat[SB_ALO] || m_stat[SB_BBL]) &&
                      (attempts_q < ATT_W'(RETRIES)) && !wr_started_q;
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RST;
            phase_q      <= PH_ADDR;
            hdr_q        <= '0;
            cnt_q        <= '0;
            err_q        <= E_NONE;
            err_pend_q   <= E_NONE;
            req_ready_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            m_ws_q       <= 1'b0;
            m_cmd_q      <= '0;
            m_dat_q      <= '0;
            rd_data_q    <= '0;
`ifdef I2C_SEQ_RETRY_EN
            attempts_q   <= '0;
            bo_q         <= '0;
            len_q        <= '0;
            wr_started_q <= 1'b0;
`endif
        end else begin
            m_ws_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                S_RST: if (!m_stat[SB_BSY]) state_q <= S_IDLE;
                S_IDLE: begin
                    if (req_ready_q && req_valid) begin
                        req_ready_q  <= 1'b0;
                        hdr_q        <= '{rd: req_rd, dev: req_dev, rga: req_reg};
                        cnt_q        <= req_len;
                        err_q        <= E_NONE;
                        err_pend_q   <= E_NONE;
                        phase_q      <= PH_ADDR;
                        state_q      <= S_ISSUE;
`ifdef I2C_SEQ_RETRY_EN
                        attempts_q   <= '0;
                        len_q        <= req_len;
                        wr_started_q <= 1'b0;
`endif
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (issue_ok) begin
                        m_cmd_q <= cmd_d;
                        m_dat_q <= dat_d;
                        m_ws_q  <= 1'b1;
                        if (phase_q == PH_DATA) begin
                            wr_ready_q   <= 1'b1;
`ifdef I2C_SEQ_RETRY_EN
                            wr_started_q <= 1'b1;
`endif
                        end
                        state_q <= S_ACPT;
                    end
                end
                S_ACPT: state_q <= S_WAIT;
                S_WAIT: if (!m_stat[SB_BSY]) state_q <= S_EVAL;
                S_EVAL: begin
                    if (phase_q == PH_STOP) begin
                        done_q  <= 1'b1;
                        err_q   <= err_pend_q;
                        state_q <= S_IDLE;
                    end else if (m_stat[SB_ERR]) begin
`ifdef I2C_SEQ_RETRY_EN
                        if (retry_ok) begin
                            attempts_q <= attempts_q + 1'b1;
                            bo_q       <= BO_W'(BACKOFF);
                            state_q    <= S_BACKOFF;
                        end else begin
                            done_q  <= 1'b1;
                            err_q   <= err_d;
                            state_q <= S_IDLE;
                        end
`else
                        done_q  <= 1'b1;
                        err_q   <= err_d;
                        state_q <= S_IDLE;
`endif
                    end else if (phase_q != PH_RDAT && !m_stat[SB_ACK]) begin
                        err_pend_q <= (phase_q == PH_ADDR || phase_q == PH_RADDR) ? E_NAKA : E_NAKD;
                        phase_q    <= PH_STOP;
                        state_q    <= S_ISSUE;
                    end else begin
                        state_q <= S_ISSUE;
                        unique case (phase_q)
                            PH_ADDR:  phase_q <= PH_REG;
                            PH_REG:   phase_q <= hdr_q.rd ? PH_RADDR : PH_DATA;
                            PH_RADDR: phase_q <= PH_RDAT;
                            PH_DATA, PH_RDAT: begin
                                if (phase_q == PH_RDAT) begin
                                    rd_data_q  <= m_dat_in;
                                    rd_valid_q <= 1'b1;
                                end
                                if (last) begin
                                    done_q  <= 1'b1;
                                    err_q   <= E_NONE;
                                    state_q <= S_IDLE;
                                end else begin
                                    cnt_q <= cnt_q - 1'b1;
                                end
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
`ifdef I2C_SEQ_RETRY_EN
                S_BACKOFF: begin
                    if (bo_q == '0) begin
                        phase_q <= PH_ADDR;
                        cnt_q   <= len_q;
                        state_q <= S_ISSUE;
                    end else begin
                        bo_q <= bo_q - 1'b1;
                    end
                end
`endif
                default: state_q <= S_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xact_seq.sv
// Self-checking bench for i2c_xact_seq with a behavioural i2c_master model scripted per test.
module tb_i2c_xact_seq;
    import i2c_xact_seq_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_rd = 1'b0;
    logic [6:0]      req_dev = '0;
    logic [7:0]      req_reg = '0;
    logic [3:0]      req_len = '0;
    logic [7:0]      wr_data = '0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            done;
    logic [2:0]      err_code;
    logic [C_SZ-1:0] m_cmd;
    logic [7:0]      m_dat;
    logic            m_ws;
    logic [S_SZ-1:0] m_stat;
    logic [7:0]      m_dat_in;

    int checks = 0;
    int errors = 0;

    i2c_xact_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err_code(err_code),
        .m_cmd(m_cmd), .m_dat(m_dat), .m_ws(m_ws), .m_stat(m_stat), .m_dat_in(m_dat_in)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural master ----------------
    int         nak_k   = -1;   // command index NAKed by the slave
    int         proto_k = -1;   // command index reporting a generic error
    int         bbl_n   = 0;    // first bbl_n commands rejected with bus-busy
    logic [7:0] cfg_rd [0:7];
    logic [C_SZ-1:0] log_cmd [$];
    logic [7:0]      log_dat [$];

    logic bsy, ack, err, alo, bbl;
    logic [7:0] dout;
    int lat;
    int k;

    assign m_stat   = {bbl, alo, err, ack, bsy};
    assign m_dat_in = dout;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bsy <= 1'b1; lat <= 5; ack <= 1'b0; err <= 1'b0; alo <= 1'b0; bbl <= 1'b0; dout <= '0;
        end else if (m_ws) begin
            k = log_cmd.size();
            log_cmd.push_back(m_cmd);
            log_dat.push_back(m_dat);
            alo <= 1'b0;
            if (k < bbl_n) begin
                bsy <= 1'b0; err <= 1'b1; bbl <= 1'b1; ack <= 1'b0;
            end else begin
                bsy <= 1'b1; lat <= 3; bbl <= 1'b0;
                err <= (k == proto_k);
                ack <= (k != nak_k) && !(m_cmd[CB_STRT] && m_dat[7:1] != 7'h50);
                if (m_cmd[CB_READ] && k >= 3 && k < 11) dout <= cfg_rd[k-3];
            end
        end else if (bsy) begin
            if (lat == 0) bsy <= 1'b0;
            else lat <= lat - 1;
        end
    end

    // ---------------- write stream, read capture, done counter ----------------
    logic [7:0] wq [$];
    int wi = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [7:0] rdv [$];

    always @(negedge clk) begin
        if (wr_ready) begin wi++; wr_cnt++; end
        if (rd_valid) rdv.push_back(rd_data);
        if (done) done_cnt++;
        wr_valid = (wi < wq.size());
        wr_data  = wr_valid ? wq[wi] : 8'h00;
    end

    logic [2:0] err_at_done;
    logic       ready_at_done;

    task automatic setup(input int nk, input int pk, input int bn);
        nak_k = nk; proto_k = pk; bbl_n = bn;
        log_cmd.delete(); log_dat.delete(); rdv.delete();
        wr_cnt = 0; wi = 0;
    endtask

    task automatic start_req(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [3:0] len);
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout got %b want 1", req_ready);
        end
        req_rd = rd; req_dev = dev; req_reg = rg; req_len = len; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout got %b want 1", done);
        end
        err_at_done   = err_code;
        ready_at_done = req_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n = 0;
        #1;
        checks++;
        if ({req_ready, done, m_ws, wr_ready, rd_valid, err_code} !== 8'h00) begin
            errors++; $display("FAIL reset_outputs got %h want 00",
                               {req_ready, done, m_ws, wr_ready, rd_valid, err_code});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_while_bsy got %b want 0", req_ready); end
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_bsy got %b want 1", req_ready); end
    endtask

    task automatic test_write();
        logic [C_SZ-1:0] ec [4] = '{5'h05, 5'h04, 5'h04, 5'h06};
        logic [7:0]      ed [4] = '{8'hA0, 8'h10, 8'hA5, 8'h3C};
        int d0;
        setup(-1, -1, 0);
        wq = '{8'hA5, 8'h3C};
        d0 = done_cnt;
        start_req(1'b0, 7'h50, 8'h10, 4'd1);
        wait_done();
        checks++;
        if (log_cmd.size() != 4) begin errors++; $display("FAIL wr_ncmd got %0d want 4", log_cmd.size()); end
        for (int i = 0; i < 4 && i < log_cmd.size(); i++) begin
            checks++;
            if (log_cmd[i] !== ec[i] || log_dat[i] !== ed[i]) begin
                errors++; $display("FAIL wr_cmd%0d got %h/%h want %h/%h", i, log_cmd[i], log_dat[i], ec[i], ed[i]);
            end
        end
        checks++;
        if (err_at_done !== 3'(E_NONE)) begin errors++; $display("FAIL wr_err got %0d want 0", err_at_done); end
        checks++;
        if (wr_cnt != 2) begin errors++; $display("FAIL wr_ready_cnt got %0d want 2", wr_cnt); end
        checks++;
        if (ready_at_done !== 1'b0) begin errors++; $display("FAIL wr_ready_at_done got %b want 0", ready_at_done); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_after_done got %b want 1", req_ready); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_cnt got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_read();
        logic [C_SZ-1:0] ec [6] = '{5'h05, 5'h04, 5'h05, 5'h08, 5'h08, 5'h1A};
        logic [7:0]      ed [3] = '{8'hA0, 8'h10, 8'hA1};
        logic [7:0]      er [3] = '{8'h11, 8'h22, 8'h33};
        setup(-1, -1, 0);
        wq.delete();
        cfg_rd[0] = 8'h11; cfg_rd[1] = 8'h22; cfg_rd[2] = 8'h33;
        start_req(1'b1, 7'h50, 8'h10, 4'd2);
        wait_done();
        @(negedge clk);
        checks++;
        if (log_cmd.size() != 6) begin errors++; $display("FAIL rd_ncmd got %0d want 6", log_cmd.size()); end
        for (int i = 0; i < 6 && i < log_cmd.size(); i++) begin
            checks++;
            if (log_cmd[i] !== ec[i] || (i < 3 && log_dat[i] !== ed[i])) begin
                errors++; $display("FAIL rd_cmd%0d got %h/%h want %h", i, log_cmd[i], log_dat[i], ec[i]);
            end
        end
        checks++;
        if (rdv.size() != 3) begin errors++; $display("FAIL rd_nbytes got %0d want 3", rdv.size()); end
        for (int i = 0; i < 3 && i < rdv.size(); i++) begin
            checks++;
            if (rdv[i] !== er[i]) begin errors++; $display("FAIL rd_byte%0d got %h want %h", i, rdv[i], er[i]); end
        end
        checks++;
        if (err_at_done !== 3'(E_NONE)) begin errors++; $display("FAIL rd_err got %0d want 0", err_at_done); end
    endtask

    task automatic test_naka();
        setup(-1, -1, 0);
        wq = '{8'h99};
        start_req(1'b0, 7'h51, 8'h10, 4'd0);
        wait_done();
        checks++;
        if (log_cmd.size() != 2) begin errors++; $display("FAIL naka_ncmd got %0d want 2", log_cmd.size()); end
        else begin
            checks++;
            if (log_cmd[0] !== 5'h05 || log_dat[0] !== 8'hA2 || log_cmd[1] !== 5'h02) begin
                errors++; $display("FAIL naka_cmds got %h/%h,%h want 05/a2,02", log_cmd[0], log_dat[0], log_cmd[1]);
            end
        end
        checks++;
        if (err_at_done !== 3'(E_NAKA)) begin errors++; $display("FAIL naka_err got %0d want 1", err_at_done); end
        checks++;
        if (wr_cnt != 0) begin errors++; $display("FAIL naka_wr_ready got %0d want 0", wr_cnt); end
        @(negedge clk);
        checks++;
        if (err_code !== 3'(E_NAKA)) begin errors++; $display("FAIL naka_err_held got %0d want 1", err_code); end
    endtask

    task automatic test_nakd();
        logic [C_SZ-1:0] ec [5] = '{5'h05, 5'h04, 5'h04, 5'h04, 5'h02};
        logic [7:0]      ed [4] = '{8'hA0, 8'h10, 8'h01, 8'h02};
        setup(3, -1, 0);
        wq = '{8'h01, 8'h02, 8'h03, 8'h04};
        start_req(1'b0, 7'h50, 8'h10, 4'd3);
        wait_done();
        checks++;
        if (log_cmd.size() != 5) begin errors++; $display("FAIL nakd_ncmd got %0d want 5", log_cmd.size()); end
        for (int i = 0; i < 5 && i < log_cmd.size(); i++) begin
            checks++;
            if (log_cmd[i] !== ec[i] || (i < 4 && log_dat[i] !== ed[i])) begin
                errors++; $display("FAIL nakd_cmd%0d got %h/%h want %h", i, log_cmd[i], log_dat[i], ec[i]);
            end
        end
        checks++;
        if (err_at_done !== 3'(E_NAKD)) begin errors++; $display("FAIL nakd_err got %0d want 2", err_at_done); end
        checks++;
        if (wr_cnt != 2) begin errors++; $display("FAIL nakd_wr_ready got %0d want 2", wr_cnt); end
        wq.delete(); wi = 0;
    endtask

    task automatic test_proto();
        setup(-1, 1, 0);
        wq = '{8'h55};
        start_req(1'b0, 7'h50, 8'h20, 4'd0);
        wait_done();
        checks++;
        if (log_cmd.size() != 2) begin errors++; $display("FAIL proto_ncmd got %0d want 2", log_cmd.size()); end
        checks++;
        if (err_at_done !== 3'(E_PROTO)) begin errors++; $display("FAIL proto_err got %0d want 5", err_at_done); end
        checks++;
        if (wr_cnt != 0) begin errors++; $display("FAIL proto_wr_ready got %0d want 0", wr_cnt); end
        wq.delete(); wi = 0;
    endtask

    task automatic test_bbl();
        setup(-1, -1, 1);
        wq = '{8'h77};
        start_req(1'b0, 7'h50, 8'h10, 4'd0);
        wait_done();
`ifdef I2C_SEQ_RETRY_EN
        checks++;
        if (log_cmd.size() != 4) begin errors++; $display("FAIL bbl_ncmd got %0d want 4", log_cmd.size()); end
        else begin
            checks++;
            if (log_cmd[1] !== 5'h05 || log_cmd[3] !== 5'h06 || log_dat[3] !== 8'h77) begin
                errors++; $display("FAIL bbl_retry_cmds got %h,%h/%h want 05,06/77", log_cmd[1], log_cmd[3], log_dat[3]);
            end
        end
        checks++;
        if (err_at_done !== 3'(E_NONE)) begin errors++; $display("FAIL bbl_err got %0d want 0", err_at_done); end
        checks++;
        if (wr_cnt != 1) begin errors++; $display("FAIL bbl_wr_ready got %0d want 1", wr_cnt); end
`else
        checks++;
        if (log_cmd.size() != 1) begin errors++; $display("FAIL bbl_ncmd got %0d want 1", log_cmd.size()); end
        checks++;
        if (err_at_done !== 3'(E_BBL)) begin errors++; $display("FAIL bbl_err got %0d want 4", err_at_done); end
        checks++;
        if (wr_cnt != 0) begin errors++; $display("FAIL bbl_wr_ready got %0d want 0", wr_cnt); end
`endif
        wq.delete(); wi = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int d0;
        setup(-1, -1, 0);
        wq.delete();
        cfg_rd[0] = 8'h44; cfg_rd[1] = 8'h55; cfg_rd[2] = 8'h66; cfg_rd[3] = 8'h77;
        start_req(1'b1, 7'h50, 8'h30, 4'd3);
        while (log_cmd.size() < 4 && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (log_cmd.size() < 4) begin errors++; $display("FAIL rstmid_reach_rdat got %0d want 4", log_cmd.size()); end
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, done, m_ws, wr_ready, rd_valid, err_code, m_cmd, m_dat, rd_data} !== 29'h0) begin
            errors++; $display("FAIL rstmid_outputs got %h want 0",
                               {req_ready, done, m_ws, wr_ready, rd_valid, err_code, m_cmd, m_dat, rd_data});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done got %0d want %0d", done_cnt, d0); end
    endtask

    task automatic test_back_to_back();
        setup(-1, -1, 0);
        wq.delete();
        cfg_rd[0] = 8'h5A;
        start_req(1'b1, 7'h50, 8'h40, 4'd0);
        wait_done();
        @(negedge clk);
        checks++;
        if (log_cmd.size() != 4 || log_cmd[3] !== 5'h1A) begin
            errors++; $display("FAIL b2b_rd_cmds got n=%0d want n=4 last 1a", log_cmd.size());
        end
        checks++;
        if (rdv.size() != 1 || rdv[0] !== 8'h5A) begin
            errors++; $display("FAIL b2b_rd_byte got n=%0d want 5a", rdv.size());
        end
        test_write();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_naka();
        test_nakd();
        test_proto();
        test_bbl();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
